// File: rtl/dot5_seq_ctrl_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dot5_seq_ctrl_if : job, chunk, datapath and result bundle for            |
// |                    dot5_seq_ctrl                                         |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
interface dot5_seq_ctrl_if #(
  parameter int LEN_W = 10,
  parameter int ACC_W = 32
);
  logic             start_vld;
  logic             start_rdy;
  logic [LEN_W-1:0] start_len;
  logic             in_vld;
  logic             in_rdy;
  logic [39:0]      in_a;
  logic [39:0]      in_b;
  logic [39:0]      dp_a;
  logic [39:0]      dp_b;
  logic [17:0]      dp_dout;
  logic             res_vld;
  logic             res_rdy;
  logic [ACC_W-1:0] res_data;
  logic             res_ovf;
  logic             busy;

  modport slave (
    input  start_vld, start_len, in_vld, in_a, in_b, dp_dout, res_rdy,
    output start_rdy, in_rdy, dp_a, dp_b, res_vld, res_data, res_ovf, busy
  );

  modport master (
    output start_vld, start_len, in_vld, in_a, in_b, dp_dout, res_rdy,
    input  start_rdy, in_rdy, dp_a, dp_b, res_vld, res_data, res_ovf, busy
  );
endinterface
`default_nettype wire

// File: rtl/dot5_seq_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dot5_seq_ctrl : job sequencer and accumulator for the sum-of-5 signed    |
// |                 8x8 dot-product datapath. DOT5_SEQ_SAT_EN = saturating.  |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module dot5_seq_ctrl #(
  parameter int DP_LAT = 3,
  parameter int LEN_W  = 10,
  parameter int ACC_W  = 32
) (
  input wire             clk,
  input wire             rst_n,
  dot5_seq_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [1:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_issued;
  logic [LEN_W-1:0] r_retired;
  logic [DP_LAT:0]  r_vpipe;
  logic [39:0]      r_dp_a;
  logic [39:0]      r_dp_b;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;

  logic             w_start;
  logic             w_in_rdy;
  logic             w_accept;
  logic             w_last;
  logic             w_retire;
  logic             w_drained;
  logic [LEN_W-1:0] w_retired_nxt;
  logic [ACC_W-1:0] w_dout_ext;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_ovf_nxt;

  assign w_start       = (r_state == S_IDLE) & bus.start_vld;
  assign w_in_rdy      = (r_state == S_RUN) && (r_issued < r_len);
  assign w_accept      = bus.in_vld & w_in_rdy;
  assign w_last        = w_accept && ((r_issued + LEN_ONE) == r_len);
  assign w_retire      = r_vpipe[DP_LAT];
  assign w_retired_nxt = r_retired + (w_retire ? LEN_ONE : '0);
  // Look one cycle ahead so DONE is entered right after the final retire.
  assign w_drained     = ~|r_vpipe[DP_LAT-1:0] && (r_issued == w_retired_nxt);
  assign w_dout_ext    = {{(ACC_W-18){bus.dp_dout[17]}}, bus.dp_dout};

`ifdef DOT5_SEQ_SAT_EN
  logic [ACC_W:0] w_sum;

  assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_dout_ext[ACC_W-1], w_dout_ext};

  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
    w_ovf_nxt = 1'b0;
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      w_ovf_nxt = 1'b1;
      w_acc_nxt = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign w_acc_nxt = r_acc + w_dout_ext;
  assign w_ovf_nxt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_issued  <= '0;
      r_retired <= '0;
      r_vpipe   <= '0;
      r_dp_a    <= '0;
      r_dp_b    <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_dp_a  <= w_accept ? bus.in_a : '0;
      r_dp_b  <= w_accept ? bus.in_b : '0;
      r_vpipe <= {r_vpipe[DP_LAT-1:0], w_accept};
      if (w_start) begin
        r_len     <= bus.start_len;
        r_issued  <= '0;
        r_retired <= '0;
        r_acc     <= '0;
        r_ovf     <= 1'b0;
        r_state   <= (bus.start_len != '0) ? S_RUN : S_DRAIN;
      end else begin
        if (w_accept) begin
          r_issued <= r_issued + LEN_ONE;
        end
        if (w_retire) begin
          r_retired <= w_retired_nxt;
          r_acc     <= w_acc_nxt;
          r_ovf     <= r_ovf | w_ovf_nxt;
        end
        case (r_state)
          S_RUN:   if (w_last)      r_state <= S_DRAIN;
          S_DRAIN: if (w_drained)   r_state <= S_DONE;
          S_DONE:  if (bus.res_rdy) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.start_rdy = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.in_rdy    = w_in_rdy;
  assign bus.dp_a      = r_dp_a;
  assign bus.dp_b      = r_dp_b;
  assign bus.res_vld   = (r_state == S_DONE);
  assign bus.res_data  = r_acc;
  assign bus.res_ovf   = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_dot5_seq_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_dot5_seq_ctrl : self-checking bench; a 32-bit and a 20-bit            |
// |                    accumulator instance share one stimulus driver        |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_dot5_seq_ctrl;
  localparam int DP_LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        start_vld;
  logic [10:0] start_len;
  logic        in_vld;
  logic [39:0] in_a;
  logic [39:0] in_b;
  logic        res_rdy;

  dot5_seq_ctrl_if #(.LEN_W(11), .ACC_W(32)) ifm ();
  dot5_seq_ctrl_if #(.LEN_W(10), .ACC_W(20)) ifo ();

  dot5_seq_ctrl #(.DP_LAT(DP_LAT), .LEN_W(11), .ACC_W(32)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(ifm)
  );
  dot5_seq_ctrl #(.DP_LAT(DP_LAT), .LEN_W(10), .ACC_W(20)) u_ovf (
    .clk(clk), .rst_n(rst_n), .bus(ifo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int chunk_sum(input logic [39:0] a, input logic [39:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 5; i++) s += int'($signed(a[8*i+:8])) * int'($signed(b[8*i+:8]));
    return s;
  endfunction

  // Datapath stand-ins: DP_LAT register stages, never reset.
  logic [17:0] dpm [DP_LAT];
  logic [17:0] dpo [DP_LAT];
  always @(posedge clk) begin
    dpm[0] <= 18'(chunk_sum(ifm.dp_a, ifm.dp_b));
    dpo[0] <= 18'(chunk_sum(ifo.dp_a, ifo.dp_b));
    for (int k = 1; k < DP_LAT; k++) begin
      dpm[k] <= dpm[k-1];
      dpo[k] <= dpo[k-1];
    end
  end

  assign ifm.start_vld = start_vld & ~sel;
  assign ifo.start_vld = start_vld & sel;
  assign ifm.start_len = start_len;
  assign ifo.start_len = start_len[9:0];
  assign ifm.in_vld = in_vld;
  assign ifo.in_vld = in_vld;
  assign ifm.in_a = in_a;
  assign ifo.in_a = in_a;
  assign ifm.in_b = in_b;
  assign ifo.in_b = in_b;
  assign ifm.res_rdy = res_rdy;
  assign ifo.res_rdy = res_rdy;
  assign ifm.dp_dout = dpm[DP_LAT-1];
  assign ifo.dp_dout = dpo[DP_LAT-1];

  logic               w_start_rdy, w_in_rdy, w_res_vld, w_res_ovf, w_busy;
  logic [39:0]        w_dp_a, w_dp_b;
  logic signed [31:0] w_res;
  assign w_start_rdy = sel ? ifo.start_rdy : ifm.start_rdy;
  assign w_in_rdy    = sel ? ifo.in_rdy : ifm.in_rdy;
  assign w_res_vld   = sel ? ifo.res_vld : ifm.res_vld;
  assign w_res_ovf   = sel ? ifo.res_ovf : ifm.res_ovf;
  assign w_busy      = sel ? ifo.busy : ifm.busy;
  assign w_dp_a      = sel ? ifo.dp_a : ifm.dp_a;
  assign w_dp_b      = sel ? ifo.dp_b : ifm.dp_b;
  assign w_res       = sel ? {{12{ifo.res_data[19]}}, ifo.res_data} : ifm.res_data;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: job-level bookkeeping by cycle number.
  longint      cyc       = 0;
  bit          e_idle    = 1'b1;
  int          e_left    = 0;
  bit          e_pending = 1'b0;
  longint      e_vld_at  = 0;
  longint      e_acc     = 0;
  bit          e_ovf     = 1'b0;
  logic [39:0] e_dpa     = '0;
  logic [39:0] e_dpb     = '0;

  function automatic bit e_res_vld();
    return e_pending && (cyc >= e_vld_at);
  endfunction

  task automatic model_step();
    bit     hs;
    longint s, lim, md;
    int     w;
    w  = sel ? 20 : 32;
    hs = !e_idle && (e_left != 0) && in_vld;
    if (!rst_n) begin
      e_idle = 1'b1; e_left = 0; e_pending = 1'b0; e_acc = 0; e_ovf = 1'b0;
      e_dpa = '0; e_dpb = '0;
    end else begin
      e_dpa = hs ? in_a : '0;
      e_dpb = hs ? in_b : '0;
      if (e_idle) begin
        if (start_vld) begin
          e_idle = 1'b0; e_acc = 0; e_ovf = 1'b0;
          e_left = sel ? int'(start_len[9:0]) : int'(start_len);
          if (e_left == 0) begin e_pending = 1'b1; e_vld_at = cyc + 2; end
        end
      end else begin
        if (hs) begin
          s   = e_acc + longint'(chunk_sum(in_a, in_b));
          lim = longint'(1) << (w - 1);
`ifdef DOT5_SEQ_SAT_EN
          if (s > lim - 1) begin s = lim - 1; e_ovf = 1'b1; end
          else if (s < -lim) begin s = -lim; e_ovf = 1'b1; end
`else
          md = lim * 2;
          s  = s & (md - 1);
          if (s >= lim) s = s - md;
`endif
          e_acc  = s;
          e_left = e_left - 1;
          if (e_left == 0) begin e_pending = 1'b1; e_vld_at = cyc + 2 + DP_LAT; end
        end
        if (e_res_vld() && res_rdy) begin e_idle = 1'b1; e_pending = 1'b0; end
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("start_rdy", w_start_rdy, e_idle);
      chk("busy", w_busy, !e_idle);
      chk("in_rdy", w_in_rdy, !e_idle && (e_left != 0));
      chk("res_vld", w_res_vld, e_res_vld());
      chk("dp_a", w_dp_a, e_dpa);
      chk("dp_b", w_dp_b, e_dpb);
      if (e_res_vld()) begin
        chk("res_data", w_res, e_acc);
        chk("res_ovf", w_res_ovf, e_ovf);
      end
    end
  end

  logic [39:0] ca [1024];
  logic [39:0] cb [1024];

  // Called at a negedge; returns at a negedge with the result consumed.
  task automatic run_job(input int len, input int mode, input int hold, input int abort_at,
                         output longint got, output longint got_ovf, output longint lat,
                         output int nacc, output longint span);
    int     idx, guard;
    longint first_c, last_c;
    bit     hs, tog;
    idx = 0; guard = 0; first_c = -1; last_c = -1; tog = 1'b1;
    got = 0; got_ovf = 0; lat = -1; nacc = 0; span = -1;
    start_vld = 1'b1;
    start_len = 11'(len);
    while (!w_start_rdy && guard < 200) begin @(negedge clk); guard++; end
    if (!w_start_rdy) chk("start_timeout", 0, 1);
    @(negedge clk);
    start_vld = 1'b0;
    guard = 0;
    while (idx < len && guard < 4000) begin
      case (mode)
        0:       in_vld = 1'b1;
        1:       begin in_vld = tog; tog = !tog; end
        default: in_vld = 1'($urandom_range(0, 1));
      endcase
      in_a = ca[idx];
      in_b = cb[idx];
      hs = in_vld && w_in_rdy;
      if (hs) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        nacc++;
      end
      @(negedge clk);
      guard++;
      if (hs) idx++;
      if (abort_at >= 0 && idx == abort_at) begin
        in_vld = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        return;
      end
    end
    in_vld = 1'b0;
    if (idx < len) chk("chunk_timeout", idx, len);
    guard = 0;
    while (!w_res_vld && guard < 100) begin @(negedge clk); guard++; end
    if (!w_res_vld) chk("res_timeout", 0, 1);
    lat     = cyc - last_c;
    got     = w_res;
    got_ovf = w_res_ovf;
    span    = last_c - first_c;
    // A start presented while the result waits must be ignored.
    repeat (hold) begin
      start_vld = 1'b1;
      start_len = 11'd2;
      @(negedge clk);
    end
    start_vld = 1'b0;
    res_rdy   = 1'b1;
    @(negedge clk);
    res_rdy   = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_start_rdy"}, w_start_rdy, 1);
    chk({tag, "_in_rdy"}, w_in_rdy, 0);
    chk({tag, "_res_vld"}, w_res_vld, 0);
    chk({tag, "_res_data"}, w_res, 0);
    chk({tag, "_res_ovf"}, w_res_ovf, 0);
    chk({tag, "_busy"}, w_busy, 0);
    chk({tag, "_dp_a"}, w_dp_a, 0);
    chk({tag, "_dp_b"}, w_dp_b, 0);
  endtask

  initial begin
    longint got, gov, lat, span;
    int     nacc, jl;
    rst_n = 1'b0; sel = 1'b0; start_vld = 1'b0; start_len = '0;
    in_vld = 1'b0; in_a = '0; in_b = '0; res_rdy = 1'b0;
    repeat (5) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    reset_checks("reset");

    ca[0] = 40'h0101010101; cb[0] = 40'h0202020202;
    run_job(1, 0, 0, -1, got, gov, lat, nacc, span);
    chk("single_res", got, 10);
    chk("single_lat", lat, 5);

    for (int i = 0; i < 1024; i++) begin ca[i] = 40'h8080808080; cb[i] = 40'h8080808080; end
    run_job(1024, 0, 0, -1, got, gov, lat, nacc, span);
    chk("full_res", got, 83886080);
    chk("full_ovf", gov, 0);
    chk("full_accepts", nacc, 1024);
    chk("full_span", span, 1023);

    ca[0] = 40'h05; ca[1] = 40'hF9; ca[2] = 40'h64; ca[3] = 40'hFD;
    for (int i = 0; i < 4; i++) cb[i] = 40'h01;
    run_job(4, 1, 10, -1, got, gov, lat, nacc, span);
    chk("bubble_res", got, 95);

    run_job(0, 0, 2, -1, got, gov, lat, nacc, span);
    chk("zero_res", got, 0);
    chk("zero_accepts", nacc, 0);

    sel = 1'b1;
    for (int i = 0; i < 7; i++) begin ca[i] = 40'h8080808080; cb[i] = 40'h8080808080; end
    run_job(7, 0, 0, -1, got, gov, lat, nacc, span);
`ifdef DOT5_SEQ_SAT_EN
    chk("ovf_res", got, 524287);
    chk("ovf_flag", gov, 1);
`else
    chk("ovf_res", got, -475136);
    chk("ovf_flag", gov, 0);
`endif
    sel = 1'b0;

    for (int i = 0; i < 8; i++) begin ca[i] = 40'h7F7F7F7F7F; cb[i] = 40'h7F7F7F7F7F; end
    run_job(8, 0, 0, 3, got, gov, lat, nacc, span);
    reset_checks("midrst");
    ca[0] = 40'h0101010101; cb[0] = 40'h0101010101;
    run_job(1, 0, 0, -1, got, gov, lat, nacc, span);
    chk("post_rst_res", got, 5);

    for (int j = 0; j < 24; j++) begin
      sel = j[0];
      jl  = $urandom_range(0, 12);
      for (int i = 0; i < 12; i++) begin
        ca[i] = {8'($urandom), 32'($urandom)};
        cb[i] = {8'($urandom), 32'($urandom)};
      end
      run_job(jl, 2, $urandom_range(0, 3), -1, got, gov, lat, nacc, span);
    end
    sel = 1'b0;

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
